rf_sb: RTL and testbench
========================

Name: rf_sb

Overview:
- Parametrised successor to the CPU's 16x16 triple-ported register file: DATA_W bits wide, NUM_REGS entries deep, two read ports and one write port.
- Fully synchronous on a single rising edge, with registered reads, write-to-read bypass and synchronous reset of all contents.
- Adds a per-register scoreboard (busy bits), set when the decode stage reserves a destination and cleared when the write lands; the pipeline uses it for stall generation.

Parameters:
- DATA_W, 16, data width of each register and each port.
- NUM_REGS, 16, number of registers; power of two, >= 2.
- AW, $clog2(NUM_REGS), address width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- p0_addr  input  AW  read port 0 address.
- p1_addr  input  AW  read port 1 address.
- re0  input  1  read enable, port 0.
- re1  input  1  read enable, port 1.
- p0  output  DATA_W  registered read data, port 0.
- p1  output  DATA_W  registered read data, port 1.
- p0_busy  output  1  registered scoreboard status of the register read on port 0.
- p1_busy  output  1  registered scoreboard status of the register read on port 1.
- dst_addr  input  AW  write address.
- dst  input  DATA_W  write data.
- we  input  1  write enable.
- rsv_addr  input  AW  register to mark busy (pending writer issued).
- rsv  input  1  reserve strobe.
- flush  input  1  clears all busy bits (pipeline flush).
- busy_vec  output  NUM_REGS  current scoreboard, bit i = register i busy.

Behaviour:
- Reset (rst=1 at an edge): all registers become 0, busy_vec=0, p0=p1=0, p0_busy=p1_busy=0. Reset overrides we, rsv and flush in the same cycle.
- Write: if we, mem[dst_addr] <= dst at the edge. A write to address 0 is discarded when RF_ZERO_REG_EN is defined.
- Read latency is 1 cycle. If re0 at edge N, p0 shows data from edge N onward; if re0=0, p0 and p0_busy hold. Port 1 behaves identically and independently.
- Bypass: if reN && we && pN_addr==dst_addr, pN <= dst (the new value), not the stale array value.
- Both read ports may read the same address in the same cycle; both return identical data.
- Scoreboard priority per bit i, highest first:
  - rst.
  - flush: bit cleared.
  - rsv && rsv_addr==i: bit set.
  - we && dst_addr==i: bit cleared.
  - otherwise hold.
- Simultaneous rsv and we to the same address leaves the bit set (the new writer is pending).
- rsv and flush in the same cycle: flush wins; the bit ends clear.
- pN_busy is captured with pN when reN=1. Its value is the busy bit after this cycle's write-clear but before this cycle's reserve: busy[addr] && !(we && dst_addr==addr). So a bypassed read is never reported busy.
- busy_vec is the registered scoreboard state, no combinational path from inputs.
- Register 0 never becomes busy when RF_ZERO_REG_EN is defined.
- Addresses are full AW width; no out-of-range case exists because NUM_REGS is a power of two.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero: writes ignored, reads return 0, bypass suppressed for address 0.
  - rsv to address 0 is ignored and busy_vec[0] stays 0.
- Not defined:
  - Register 0 is an ordinary register: writable, bypassable and reservable like any other.

Test Plan:
- Reset then read: rst=1 one cycle, then re0=1 p0_addr=5 -> p0=0x0000, p0_busy=0, busy_vec=0 one cycle later.
- Write then read: we=1 dst_addr=3 dst=0xBEEF, next cycle re1=1 p1_addr=3 -> p1=0xBEEF after one edge.
- Bypass: same cycle we=1 dst_addr=7 dst=0x1234 and re0=1 p0_addr=7 -> p0=0x1234 after the edge, p0_busy=0 even if reg 7 was previously reserved.
- Scoreboard:
  - rsv=1 rsv_addr=9 -> busy_vec[9]=1.
  - Read of 9 -> p0_busy=1.
  - we to 9 -> bit clears.
  - rsv+we to 9 in the same cycle -> bit stays 1.
  - flush+rsv to 9 -> bit 0.
- Zero register, with RF_ZERO_REG_EN: we=1 dst_addr=0 dst=0xFFFF, rsv to 0, then read 0 -> p0=0, busy_vec[0]=0.
- Zero register, without RF_ZERO_REG_EN: same stimulus -> p0=0xFFFF and busy_vec[0] set by rsv.
- Hold and reset mid-operation: after p0=0xBEEF, re0=0 for 3 cycles with writes to that address -> p0 stays 0xBEEF. Then rst=1 with we=1 in the same cycle -> all state 0, the write is lost.

Source files
------------

// File: rtl/rf_sb.sv
// rf_sb -- parametrised 2-read / 1-write register file with per-register
// scoreboard (busy bits) for pipeline stall generation.
//
// All state updates on the rising edge of clk; rst is synchronous, active-high
// and clears the array, the read registers and the scoreboard.
//
// Ports:
//   clk, rst                 clock and synchronous reset
//   p0_addr, re0 -> p0, p0_busy   read port 0 (1-cycle latency, holds when re0=0)
//   p1_addr, re1 -> p1, p1_busy   read port 1 (same behaviour, independent)
//   dst_addr, dst, we        write port; same-cycle reads of dst_addr see dst
//   rsv_addr, rsv            mark a register busy (pending writer issued)
//   flush                    clear every busy bit
//   busy_vec                 registered scoreboard, bit i = register i busy
//
// Optional feature, macro RF_ZERO_REG_EN: register 0 is hardwired to zero
// (writes ignored, reads return 0, no bypass) and can never become busy.
// Without the macro register 0 is an ordinary register.

module rf_sb #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 16,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       p0_addr,
  input  logic [AW-1:0]       p1_addr,
  input  logic                re0,
  input  logic                re1,
  output logic [DATA_W-1:0]   p0,
  output logic [DATA_W-1:0]   p1,
  output logic                p0_busy,
  output logic                p1_busy,
  input  logic [AW-1:0]       dst_addr,
  input  logic [DATA_W-1:0]   dst,
  input  logic                we,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                rsv,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec
);

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  logic [DATA_W-1:0]   mem_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  logic                we_eff;
  logic                rsv_eff;
  logic [DATA_W-1:0]   p0_next;
  logic [DATA_W-1:0]   p1_next;
  logic                p0_busy_next;
  logic                p1_busy_next;

  // With the zero register enabled, writes and reservations of register 0
  // are dropped here so that the array, the bypass and the scoreboard all
  // see the same filtered request.
  assign we_eff  = we  && !(ZERO_REG_EN && (dst_addr == '0));
  assign rsv_eff = rsv && !(ZERO_REG_EN && (rsv_addr == '0));

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we_eff) begin
      mem_reg[dst_addr] <= dst;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data selection: bypass the incoming write so a same-cycle read never
  // returns the stale array value.
  // ---------------------------------------------------------------------------
  always_comb begin
    p0_next = mem_reg[p0_addr];
    if (we_eff && (p0_addr == dst_addr)) begin
      p0_next = dst;
    end
    if (ZERO_REG_EN && (p0_addr == '0)) begin
      p0_next = '0;
    end
  end

  always_comb begin
    p1_next = mem_reg[p1_addr];
    if (we_eff && (p1_addr == dst_addr)) begin
      p1_next = dst;
    end
    if (ZERO_REG_EN && (p1_addr == '0)) begin
      p1_next = '0;
    end
  end

  // Reported busy status includes this cycle's write-clear but not this
  // cycle's reserve, so a bypassed read is never flagged busy.
  assign p0_busy_next = busy_reg[p0_addr] && !(we && (dst_addr == p0_addr));
  assign p1_busy_next = busy_reg[p1_addr] && !(we && (dst_addr == p1_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      p0      <= '0;
      p1      <= '0;
      p0_busy <= 1'b0;
      p1_busy <= 1'b0;
    end else begin
      if (re0) begin
        p0      <= p0_next;
        p0_busy <= p0_busy_next;
      end
      if (re1) begin
        p1      <= p1_next;
        p1_busy <= p1_busy_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: per-bit priority flush > reserve > write-clear > hold.
  // Reserve beating write-clear keeps the bit set when a new writer is issued
  // in the same cycle the previous one retires.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      always_comb begin
        busy_next[gi] = busy_reg[gi];
        if (flush) begin
          busy_next[gi] = 1'b0;
        end else if (rsv_eff && (rsv_addr == AW'(gi))) begin
          busy_next[gi] = 1'b1;
        end else if (we && (dst_addr == AW'(gi))) begin
          busy_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

endmodule

// File: tb/tb_rf_sb.sv
// Directed, table-driven bench for rf_sb (DATA_W=16, NUM_REGS=16).
// Each record holds one cycle of inputs and the outputs expected just after
// that cycle's rising edge. Expectations for register 0 follow RF_ZERO_REG_EN.

module tb_rf_sb;

`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  p0_addr = '0, p1_addr = '0, dst_addr = '0, rsv_addr = '0;
  logic        re0 = 1'b0, re1 = 1'b0, we = 1'b0, rsv = 1'b0, flush = 1'b0;
  logic [15:0] dst = '0;
  logic [15:0] p0, p1;
  logic        p0_busy, p1_busy;
  logic [15:0] busy_vec;

  always #5 clk = ~clk;

  rf_sb #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
    .p0(p0), .p1(p1), .p0_busy(p0_busy), .p1_busy(p1_busy),
    .dst_addr(dst_addr), .dst(dst), .we(we),
    .rsv_addr(rsv_addr), .rsv(rsv), .flush(flush),
    .busy_vec(busy_vec)
  );

  typedef struct packed {
    logic        rst;
    logic        re0;
    logic [3:0]  a0;
    logic        re1;
    logic [3:0]  a1;
    logic        we;
    logic [3:0]  da;
    logic [15:0] d;
    logic        rsv;
    logic [3:0]  ra;
    logic        flush;
    logic [15:0] e_p0;
    logic [15:0] e_p1;
    logic        e_b0;
    logic        e_b1;
    logic [15:0] e_busy;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(
    input logic r, input logic r0, input logic [3:0] a0, input logic r1, input logic [3:0] a1,
    input logic w, input logic [3:0] da, input logic [15:0] d,
    input logic rv, input logic [3:0] ra, input logic fl,
    input logic [15:0] e0, input logic [15:0] e1, input logic eb0, input logic eb1,
    input logic [15:0] ebusy);
    vec_t v;
    v.rst = r; v.re0 = r0; v.a0 = a0; v.re1 = r1; v.a1 = a1;
    v.we = w; v.da = da; v.d = d; v.rsv = rv; v.ra = ra; v.flush = fl;
    v.e_p0 = e0; v.e_p1 = e1; v.e_b0 = eb0; v.e_b1 = eb1; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, got, want);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the rising edge.
  task automatic run(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    rst = v.rst; re0 = v.re0; p0_addr = v.a0; re1 = v.re1; p1_addr = v.a1;
    we = v.we; dst_addr = v.da; dst = v.d; rsv = v.rsv; rsv_addr = v.ra; flush = v.flush;
    @(posedge clk);
    #1;
    cmp({tag, ".p0"}, idx, p0, v.e_p0);
    cmp({tag, ".p1"}, idx, p1, v.e_p1);
    cmp({tag, ".p0_busy"}, idx, {15'd0, p0_busy}, {15'd0, v.e_b0});
    cmp({tag, ".p1_busy"}, idx, {15'd0, p1_busy}, {15'd0, v.e_b1});
    cmp({tag, ".busy_vec"}, idx, busy_vec, v.e_busy);
    $display("%s[%0d] p0=%h p1=%h b0=%0d b1=%0d busy=%h", tag, idx, p0, p1, p0_busy, p1_busy, busy_vec);
  endtask

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    //            rst re0 a0 re1 a1 we da d         rsv ra fl  e_p0      e_p1      b0 b1 busy
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000); // reset
    vecs[1]  = mk(0, 1, 5, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000); // read after reset
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 3, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000); // write 3
    vecs[3]  = mk(0, 0, 0, 1, 3, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'hBEEF, 0, 0, 16'h0000); // read 3 on p1
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 7, 0, 16'h0000, 16'hBEEF, 0, 0, 16'h0080); // reserve 7
    vecs[5]  = mk(0, 1, 7, 0, 0, 1, 7, 16'h1234, 0, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 16'h0000); // bypass, not busy
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 9, 0, 16'h1234, 16'hBEEF, 0, 0, 16'h0200); // reserve 9
    vecs[7]  = mk(0, 1, 9, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'hBEEF, 1, 0, 16'h0200); // read busy 9
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 9, 16'h5555, 0, 0, 0, 16'h0000, 16'hBEEF, 1, 0, 16'h0000); // write clears 9
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 9, 0, 16'h0000, 16'hBEEF, 1, 0, 16'h0200); // reserve 9 again
    vecs[10] = mk(0, 0, 0, 1, 9, 1, 9, 16'h6666, 1, 9, 0, 16'h0000, 16'h6666, 1, 0, 16'h0200); // rsv+we: stays set
    vecs[11] = mk(0, 1, 9, 0, 0, 0, 0, 16'h0000, 1, 9, 1, 16'h6666, 16'h6666, 1, 0, 16'h0000); // flush beats rsv
    vecs[12] = mk(0, 1, 9, 1, 9, 0, 0, 16'h0000, 0, 0, 0, 16'h6666, 16'h6666, 0, 0, 16'h0000); // same addr both ports
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 5, 16'hAAAA, 1, 2, 0, 16'h6666, 16'h6666, 0, 0, 16'h0004); // rsv 2, write 5
    vecs[14] = mk(0, 1, 2, 1, 5, 0, 0, 16'h0000, 1, 5, 0, 16'h0000, 16'hAAAA, 1, 0, 16'h0024); // same-cycle rsv not seen
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 16'h0000, 16'hAAAA, 1, 0, 16'h0024); // write reg 0
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'hAAAA, 1, 0,
                  ZR ? 16'h0024 : 16'h0025);                                                     // reserve reg 0
    vecs[17] = mk(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, ZR ? 16'h0000 : 16'hFFFF, 16'hAAAA,
                  ZR ? 1'b0 : 1'b1, 0, ZR ? 16'h0024 : 16'h0025);                                // read reg 0
    vecs[18] = mk(0, 0, 0, 1, 0, 1, 0, 16'h1111, 0, 0, 0, ZR ? 16'h0000 : 16'hFFFF,
                  ZR ? 16'h0000 : 16'h1111, ZR ? 1'b0 : 1'b1, 0, 16'h0024);                      // bypass reg 0

    for (int i = 0; i < NV; i++) begin
      run(vecs[i], "vec", i);
    end

    // Hold: p0 captures 0xBEEF, then keeps it for 3 cycles while reg 3 is rewritten.
    run(mk(0, 1, 3, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hBEEF, ZR ? 16'h0000 : 16'h1111, 0, 0, 16'h0024), "hold", 0);
    for (int k = 1; k <= 3; k++) begin
      run(mk(0, 0, 3, 0, 0, 1, 3, 16'(k), 0, 0, 0, 16'hBEEF, ZR ? 16'h0000 : 16'h1111, 0, 0, 16'h0024), "hold", k);
    end

    // Reset wins over a same-cycle write, reserve and flush; afterwards everything reads 0.
    run(mk(1, 1, 3, 1, 3, 1, 3, 16'h7777, 1, 4, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000), "rst_mid", 0);
    run(mk(0, 1, 3, 1, 7, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), "rst_mid", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
